rename_map: RTL and testbench

//  Architectural-to-commit-station rename map for one hart. Replaces the per-register

---
 rtl/rename_map.sv | 155 +++++++++++++++
 tb/tb_rename_map.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map.sv
// Architectural-register to commit-station rename map with NWR write ports, NRD lookup
// ports, commit clearing and a multi-cycle flush rebuild. Optional FP bank: RENAME_MAP_FP_EN.
module rename_map #(
  parameter int NWR      = 4,
  parameter int NRD      = 12,
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int RA       = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NWR-1:0]          wr_valid,
  input  logic [5*NWR-1:0]        wr_rd,
  input  logic [LNCOMMIT*NWR-1:0] wr_tag,
`ifdef RENAME_MAP_FP_EN
  input  logic [NWR-1:0]          wr_fp,
  input  logic [NRD-1:0]          rd_fp,
  input  logic                    rb_rd_fp,
`endif
  input  logic [5*NRD-1:0]        rd_addr,
  output logic [RA*NRD-1:0]       rd_out,
  input  logic [NCOMMIT-1:0]      commit_done,
  input  logic                    flush,
  input  logic [LNCOMMIT-1:0]     flush_head,
  input  logic [LNCOMMIT-1:0]     flush_tail,
  input  logic                    flush_empty,
  output logic [LNCOMMIT-1:0]     rb_addr,
  input  logic                    rb_makes_rd,
  input  logic [4:0]              rb_rd,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, WALK} state_t;

  state_t                state;
  logic [LNCOMMIT-1:0]   rb_idx;
  logic [LNCOMMIT-1:0]   l_head;
  logic [LNCOMMIT-1:0]   l_tail;
  logic                  l_empty;

  // Bank 0 is integer, bank 1 is FP. Without the FP option bank 1 is never written
  // and collapses to constants.
  logic [NWR-1:0] wr_bank;
  logic [NRD-1:0] rd_bank;
  logic           rb_bank;

`ifdef RENAME_MAP_FP_EN
  assign wr_bank = wr_fp;
  assign rd_bank = rd_fp;
  assign rb_bank = rb_rd_fp;
`else
  assign wr_bank = '0;
  assign rd_bank = '0;
  assign rb_bank = 1'b0;
`endif

  logic [31:0]         ent_v   [2];
  logic [LNCOMMIT-1:0] ent_tag [2][32];
  logic [31:0]         nxt_v   [2];
  logic [LNCOMMIT-1:0] nxt_tag [2][32];

  assign busy    = flush || (state != IDLE);
  assign rb_addr = rb_idx;

  // Lookups read the pre-write table; a tag retiring this cycle reads as arch form.
  always_comb begin
    logic [4:0]          a;
    logic [LNCOMMIT-1:0] t;
    logic                b;
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rd_out = '0;
    for (int j = 0; j < NRD; j++) begin
      a = rd_addr[j*5 +: 5];
      b = rd_bank[j];
      t = ent_tag[b][a];
      if (ent_v[b][a] && !commit_done[t])
        rd_out[j*RA +: RA] = {1'b1, (RA-1)'(t)};
      else
        rd_out[j*RA +: RA] = {1'b0, (RA-1)'(a)};
    end
  end

  // Priority, lowest to highest: commit clear, CLEAR wipe, rebuild fill, rename writes.
  always_comb begin
    nxt_v   = ent_v;
    nxt_tag = ent_tag;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 32; r++)
        if (ent_v[b][r] && commit_done[ent_tag[b][r]])
          nxt_v[b][r] = 1'b0;
    if (state == CLEAR) begin
      nxt_v[0] = '0;
      nxt_v[1] = '0;
    end
    if (state == WALK && !flush && rb_makes_rd && (rb_bank || rb_rd != 5'd0)
        && !commit_done[rb_idx]) begin
      nxt_v[rb_bank][rb_rd]   = 1'b1;
      nxt_tag[rb_bank][rb_rd] = rb_idx;
    end
    if (!busy) begin
      for (int i = 0; i < NWR; i++)
        if (wr_valid[i] && (wr_bank[i] || wr_rd[i*5 +: 5] != 5'd0)) begin
          nxt_v[wr_bank[i]][wr_rd[i*5 +: 5]]   = 1'b1;
          nxt_tag[wr_bank[i]][wr_rd[i*5 +: 5]] = wr_tag[i*LNCOMMIT +: LNCOMMIT];
        end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_v[0] <= '0;
      ent_v[1] <= '0;
    end else begin
      ent_v[0] <= nxt_v[0];
      ent_v[1] <= nxt_v[1];
    end
  end

  // NOTE: only the valid bits need reset; a tag is never observed while its valid bit is clear.
  always_ff @(posedge clk) begin
    ent_tag <= nxt_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rb_idx  <= '0;
      l_head  <= '0;
      l_tail  <= '0;
      l_empty <= 1'b0;
    end else if (flush) begin
      state   <= CLEAR;
      l_head  <= flush_head;
      l_tail  <= flush_tail;
      l_empty <= flush_empty;
    end else begin
      unique case (state)
        CLEAR: begin
          if (l_empty) begin
            state <= IDLE;
          end else begin
            rb_idx <= l_head;
            state  <= WALK;
          end
        end
        WALK: begin
          if (rb_idx == l_tail) state <= IDLE;
          else rb_idx <= rb_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rename_map.sv
// Randomized self-checking bench for rename_map against a table-level reference model,
// plus directed rename, commit and flush-rebuild scenarios.
module tb_rename_map;

  localparam int NWR = 4;
  localparam int NRD = 12;
  localparam int NC  = 32;
  localparam int LN  = 5;
  localparam int RA  = 6;
`ifdef RENAME_MAP_FP_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [NWR-1:0]    wr_valid;
  logic [5*NWR-1:0]  wr_rd;
  logic [LN*NWR-1:0] wr_tag;
  logic [NWR-1:0]    wr_fp;
  logic [NRD-1:0]    rd_fp;
  logic              rb_rd_fp;
  logic [5*NRD-1:0]  rd_addr;
  logic [RA*NRD-1:0] rd_out;
  logic [NC-1:0]     commit_done;
  logic              flush;
  logic [LN-1:0]     flush_head;
  logic [LN-1:0]     flush_tail;
  logic              flush_empty;
  logic [LN-1:0]     rb_addr;
  logic              rb_makes_rd;
  logic [4:0]        rb_rd;
  logic              busy;

  // Surviving commit-station contents, answered combinationally for rb_addr.
  logic       st_makes [32];
  logic [4:0] st_rd    [32];
  logic       st_fp    [32];

  assign rb_makes_rd = st_makes[rb_addr];
  assign rb_rd       = st_rd[rb_addr];
  assign rb_rd_fp    = st_fp[rb_addr];

  rename_map #(.NWR(NWR), .NRD(NRD), .NCOMMIT(NC), .LNCOMMIT(LN), .RA(RA)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_rd       (wr_rd),
    .wr_tag      (wr_tag),
`ifdef RENAME_MAP_FP_EN
    .wr_fp       (wr_fp),
    .rd_fp       (rd_fp),
    .rb_rd_fp    (rb_rd_fp),
`endif
    .rd_addr     (rd_addr),
    .rd_out      (rd_out),
    .commit_done (commit_done),
    .flush       (flush),
    .flush_head  (flush_head),
    .flush_tail  (flush_tail),
    .flush_empty (flush_empty),
    .rb_addr     (rb_addr),
    .rb_makes_rd (rb_makes_rd),
    .rb_rd       (rb_rd),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per bank, per register, renamed flag and station number.
  bit m_v   [2][32];
  int m_tag [2][32];

  function automatic int exp_lookup(input int a, input int b);
    if (m_v[b][a] && !commit_done[m_tag[b][a]]) return (1 << (RA-1)) + m_tag[b][a];
    return a;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 32; r++) m_v[b][r] = 1'b0;
  endtask

  task automatic model_step();
    bit nv [2][32];
    int nt [2][32];
    int b, r;
    nv = m_v;
    nt = m_tag;
    for (int bb = 0; bb < 2; bb++)
      for (int rr = 0; rr < 32; rr++)
        if (m_v[bb][rr] && commit_done[m_tag[bb][rr]]) nv[bb][rr] = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_valid[i]) begin
        b = FP ? int'(wr_fp[i]) : 0;
        r = int'(wr_rd[i*5 +: 5]);
        if (b == 1 || r != 0) begin
          nv[b][r] = 1'b1;
          nt[b][r] = int'(wr_tag[i*LN +: LN]);
        end
      end
    end
    m_v   = nv;
    m_tag = nt;
  endtask

  // Survivors head..tail inclusive, oldest first; a younger station overrides an older one.
  task automatic model_rebuild(input int h, input int t, input bit e);
    int k, b;
    model_clear();
    if (!e) begin
      for (int s = 0; s < 32; s++) begin
        k = (h + s) % 32;
        b = FP ? int'(st_fp[k]) : 0;
        if (st_makes[k] && (b == 1 || st_rd[k] != 5'd0)) begin
          m_v[b][st_rd[k]]   = 1'b1;
          m_tag[b][st_rd[k]] = k;
        end
        if (k == t) break;
      end
    end
  endtask

  // One idle-map cycle: check every lookup port at negedge, then advance the model.
  task automatic tick(input int exp0 = -1);
    @(negedge clk);
    check("busy_idle", int'(busy), 0);
    for (int j = 0; j < NRD; j++)
      check($sformatf("rd%0d_r%0d", j, rd_addr[j*5 +: 5]), int'(rd_out[j*RA +: RA]),
            exp_lookup(int'(rd_addr[j*5 +: 5]), FP ? int'(rd_fp[j]) : 0));
    if (exp0 >= 0) check("directed_port0", int'(rd_out[RA-1:0]), exp0);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int i, input int r, input int t, input bit fp);
    wr_valid[i]       = 1'b1;
    wr_rd[i*5 +: 5]   = 5'(r);
    wr_tag[i*LN +: LN] = LN'(t);
    wr_fp[i]          = fp & FP;
  endtask

  task automatic set_rd(input int j, input int r, input bit fp);
    rd_addr[j*5 +: 5] = 5'(r);
    rd_fp[j]          = fp & FP;
  endtask

  task automatic check_all();
    wr_valid    = '0;
    commit_done = '0;
    for (int g = 0; g < (FP ? 6 : 3); g++) begin
      for (int j = 0; j < NRD; j++) set_rd(j, (g % 3) * 12 + j, g >= 3);
      tick();
    end
  endtask

  task automatic clear_st();
    for (int k = 0; k < 32; k++) begin
      st_makes[k] = 1'b0;
      st_rd[k]    = 5'd0;
      st_fp[k]    = 1'b0;
    end
  endtask

  task automatic set_st(input int k, input int r, input bit fp);
    st_makes[k] = 1'b1;
    st_rd[k]    = 5'(r);
    st_fp[k]    = fp & FP;
  endtask

  task automatic random_st();
    for (int k = 0; k < 32; k++) begin
      st_makes[k] = 1'($urandom_range(0, 1));
      st_rd[k]    = 5'($urandom);
      st_fp[k]    = FP ? 1'($urandom) : 1'b0;
    end
  endtask

  // Flush with optional restart at busy-cycle rcyc; checks rb_addr order and busy length.
  task automatic run_flush(input int h1, input int t1, input bit e1,
                           input int rcyc, input int h2, input int t2, input bit e2);
    int h, t, base, cyc, n;
    bit e;
    h = h1; t = t1; e = e1; base = 0;
    commit_done = '0;
    flush       = 1'b1;
    flush_head  = LN'(h1);
    flush_tail  = LN'(t1);
    flush_empty = e1;
    // Renames offered while busy must be dropped.
    for (int i = 0; i < NWR; i++) set_wr(i, $urandom_range(1, 31), $urandom, 1'($urandom));
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (rcyc > 0 && cyc == rcyc) begin
        flush       = 1'b1;
        flush_head  = LN'(h2);
        flush_tail  = LN'(t2);
        flush_empty = e2;
        h = h2; t = t2; e = e2; base = cyc;
      end
      #1;
      if (!busy) break;
      if (cyc - base >= 2) check("rb_addr", int'(rb_addr), (h + cyc - base - 2) % 32);
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    wr_valid = '0;
    n = e ? 0 : ((t - h + 32) % 32) + 1;
    check("busy_len", cyc, base + 2 + n);
    model_rebuild(h, t, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int h, t, rc;
    bit e;
    reset       = 1'b1;
    wr_valid    = '0;
    wr_rd       = '0;
    wr_tag      = '0;
    wr_fp       = '0;
    rd_fp       = '0;
    rd_addr     = '0;
    commit_done = '0;
    flush       = 1'b0;
    flush_head  = '0;
    flush_tail  = '0;
    flush_empty = 1'b0;
    clear_st();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_rb_addr", int'(rb_addr), 0);
    check_all();

    set_rd(0, 5, 0);
    tick(6'h05);
    set_wr(0, 5, 3, 0);
    tick(6'h05);
    wr_valid = '0;
    tick(6'h23);

    set_wr(1, 7, 4, 0);
    set_wr(3, 7, 6, 0);
    set_rd(0, 7, 0);
    tick();
    wr_valid = '0;
    tick(6'h26);

    set_wr(0, 9, 2, 0);
    set_rd(0, 9, 0);
    tick();
    wr_valid    = '0;
    commit_done = 32'h4;
    tick(6'h09);
    commit_done = '0;
    tick(6'h09);
    set_wr(0, 9, 2, 0);
    tick();
    commit_done = 32'h4;
    set_wr(0, 9, 8, 0);
    tick(6'h09);
    wr_valid    = '0;
    commit_done = '0;
    tick(6'h28);

    set_wr(0, 0, 11, 0);
    set_rd(0, 0, 0);
    tick();
    wr_valid = '0;
    tick(6'h00);

`ifdef RENAME_MAP_FP_EN
    set_wr(0, 2, 5, 1);
    set_wr(1, 2, 6, 0);
    tick();
    wr_valid = '0;
    set_rd(0, 2, 1);
    tick(6'h25);
    set_rd(0, 2, 0);
    tick(6'h26);
`endif

    clear_st();
    set_st(30, 3, 0);
    set_st(31, 4, 0);
    set_st(0, 3, 0);
    set_st(2, 9, 0);
    run_flush(30, 1, 1'b0, 0, 0, 0, 1'b0);
    set_rd(0, 3, 0);
    tick(6'h20);
    set_rd(0, 4, 0);
    tick(6'h3f);
    set_rd(0, 9, 0);
    tick(6'h09);
    check_all();

    set_st(5, 10, 0);
    set_st(6, 11, 0);
    set_st(7, 10, 0);
    run_flush(30, 1, 1'b0, 3, 5, 7, 1'b0);
    set_rd(0, 10, 0);
    tick(6'h27);
    set_rd(0, 3, 0);
    tick(6'h03);
    check_all();

    run_flush(12, 12, 1'b1, 0, 0, 0, 1'b0);
    check_all();

    random_st();
    flush       = 1'b1;
    flush_head  = 5'd0;
    flush_tail  = 5'd20;
    flush_empty = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rb_addr", int'(rb_addr), 0);
    model_clear();
    check_all();

    for (int c = 0; c < 600; c++) begin
      if (c % 100 == 99) begin
        random_st();
        h  = $urandom_range(0, 31);
        t  = $urandom_range(0, 31);
        e  = ($urandom_range(0, 5) == 0);
        rc = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 4) : 0;
        run_flush(h, t, e, rc, $urandom_range(0, 31), $urandom_range(0, 31),
                  ($urandom_range(0, 5) == 0));
        check_all();
      end else begin
        wr_valid = NWR'($urandom);
        for (int i = 0; i < NWR; i++) begin
          wr_rd[i*5 +: 5]    = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
          wr_tag[i*LN +: LN] = LN'($urandom);
          wr_fp[i]           = FP ? 1'($urandom) : 1'b0;
        end
        for (int j = 0; j < NRD; j++)
          set_rd(j, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                 1'($urandom));
        commit_done = $urandom & $urandom & $urandom;
        tick();
      end
    end
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
